fbmem_wb_responder: RTL
=======================

// Module: fbmem_wb_responder
// PURPOSE
//  Wishbone classic slave that serves framebuffer memory to the video line-fetch master and the CPU.
//  Two slave ports share one inferred single-port synchronous RAM of 32-bit words.
//  The video port is read-only and has priority; a starvation limit guarantees CPU progress.
//  Sits between the system interconnect / video fetch engine and on-chip framebuffer RAM.
// PARAMETERS
//  AW            13  word-address width; RAM depth = DEPTH words
//  DEPTH         8192  words implemented (<= 2**AW); 640x480x1 needs 9600 words with AW=14
//  STARVE_LIMIT  4   consecutive video grants allowed while CPU request pending
// PORTS
//  clk_i    in   1     clock, all logic on rising edge
//  rst_i    in   1     reset, asynchronous, active-high
//  vid_bus  slave if_wb  video fetch port: cyc,stb,adr[31:0],we,sel[3:0],dat_m in; ack,dat_s[31:0] out
//  cpu_bus  slave if_wb  CPU port: same signal set, read/write
// BEHAVIOUR
//  - Reset (async): state S_IDLE, both ack=0, both dat_s=0, starve count=0, CPU-pending flag=0; RAM not cleared.
//  - Word index = adr[AW+1:2]; adr[1:0] ignored. In range iff index < DEPTH.
//  - States: S_IDLE, S_RD, S_WR, S_ACK.
//  - S_IDLE: sample cyc&stb of both ports. Grant: video if only video; CPU if only CPU;
//    both -> video unless starve count == STARVE_LIMIT, then CPU. Latch granted port, index, we, sel, dat_m.
//    Granted read (or any video request) -> S_RD; CPU write -> S_WR; no request -> stay.
//  - Starve count: +1 on each video grant while CPU cyc&stb high; cleared on CPU grant or CPU cyc low.
//  - S_RD: RAM read of latched index (1-cycle RAM latency) -> S_ACK.
//  - S_WR: byte-masked RAM write per latched sel (sel[3] = bits 31:24) -> S_ACK. Out-of-range: no write.
//  - S_ACK: ack=1 for exactly one cycle on the granted port only; dat_s = RAM data (reads, in range),
//    else 0. dat_s held until next ack on that port. -> S_IDLE.
//  - Latency fixed: ack asserted 2 cycles after the edge that sampled cyc&stb (cycles: grant, RAM, ack).
//  - Request latched on stb: single-cycle stb pulse with cyc held (video fetch style) is fully served.
//  - cyc dropped by granted master before S_ACK: transaction aborted, no ack, return to S_IDLE;
//    a write already performed in S_WR is not undone.
//  - stb still high in S_IDLE after an ack: treated as a new request.
//  - Video-port we=1: acknowledged, RAM unchanged, dat_s=0.
//  - Ungranted port sees ack=0 and waits; its request is re-arbitrated in next S_IDLE.
//  - Never both acks in one cycle. Back-to-back throughput: one transaction per 3 cycles.
//  - Address arithmetic unsigned; no wrap: index >= DEPTH is out of range, never aliased.
// TESTING
//  1 CPU write adr 0x40 dat 0xDEADBEEF sel 4'hf, then read 0x40 -> each ack 2 cycles after stb, read 0xDEADBEEF.
//  2 CPU write adr 0x40 dat 0x0000AA00 sel 4'b0010 -> read 0x40 returns 0xDEADAAEF.
//  3 Video read 0x40 and CPU read 0x44 sampled same cycle -> video ack at +2 (0xDEADAAEF), CPU ack at +5.
//  4 Video continuous requests, CPU pending -> CPU granted after exactly 4 video grants; starve count clears.
//  5 Video stb 1-cycle pulse, cyc held -> ack at +2; repeat dropping cyc at +1 -> no ack, FSM back to S_IDLE.
//  6 CPU read index DEPTH -> ack, dat_s=0; CPU write there -> no RAM change; async reset during S_RD ->
//    ack stays 0, S_IDLE, RAM contents at 0x40 preserved.

Source files
------------

// File: rtl/fbmem_wb_responder.sv
// Dual-port Wishbone classic slave in front of a single-port framebuffer RAM.
// The video port is read-only and has priority; a starvation counter guarantees CPU progress.
module fbmem_wb_responder #(
    parameter int unsigned AW           = 13,
    parameter int unsigned DEPTH        = 8192,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        vid_cyc,
    input  logic        vid_stb,
    input  logic [31:0] vid_adr,
    input  logic        vid_we,
    input  logic [3:0]  vid_sel,
    input  logic [31:0] vid_dat_m,
    output logic        vid_ack,
    output logic [31:0] vid_dat_s,
    input  logic        cpu_cyc,
    input  logic        cpu_stb,
    input  logic [31:0] cpu_adr,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_sel,
    input  logic [31:0] cpu_dat_m,
    output logic        cpu_ack,
    output logic [31:0] cpu_dat_s
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 2);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_ACK} state_t;

    state_t          state, state_nxt;
    logic            vid_req, cpu_req, cpu_pend;
    logic            grant_vid, grant_cpu, gnt_cyc;
    logic            sel_vid;
    logic [31:0]     req_adr;
    logic [AW-1:0]   lat_idx;
    logic            lat_in_range, lat_we;
    logic [3:0]      lat_sel;
    logic [31:0]     lat_dat;
    logic [SW-1:0]   starve_cnt;
    logic [31:0]     ram_q, rdata;
    logic [31:0]     mem [DEPTH];
    logic            unused_bits;

    assign unused_bits = ^{vid_adr[1:0], cpu_adr[1:0], vid_sel, vid_dat_m};

    assign vid_req = vid_cyc & vid_stb;
    assign cpu_req = cpu_cyc & (cpu_stb | cpu_pend);
    assign gnt_cyc = sel_vid ? vid_cyc : cpu_cyc;
    assign req_adr = grant_vid ? vid_adr : cpu_adr;
    assign rdata   = (lat_in_range && !lat_we) ? ram_q : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_vid = 1'b0;
        grant_cpu = 1'b0;
        case (state)
            S_IDLE: begin
                if (vid_req && (!cpu_req || starve_cnt != SW'(STARVE_LIMIT))) begin
                    grant_vid = 1'b1;
                    state_nxt = S_RD;
                end else if (cpu_req) begin
                    grant_cpu = 1'b1;
                    state_nxt = cpu_we ? S_WR : S_RD;
                end
            end
            S_RD, S_WR: state_nxt = gnt_cyc ? S_ACK : S_IDLE;
            S_ACK:      state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vid_ack      <= 1'b0;
            cpu_ack      <= 1'b0;
            vid_dat_s    <= '0;
            cpu_dat_s    <= '0;
            starve_cnt   <= '0;
            cpu_pend     <= 1'b0;
            sel_vid      <= 1'b0;
            lat_idx      <= '0;
            lat_in_range <= 1'b0;
            lat_we       <= 1'b0;
            lat_sel      <= '0;
            lat_dat      <= '0;
        end else begin
            vid_ack <= 1'b0;
            cpu_ack <= 1'b0;

            if (grant_vid || grant_cpu) begin
                sel_vid      <= grant_vid;
                lat_idx      <= req_adr[AW+1:2];
                // full word index compared so upper address bits never alias into the RAM
                lat_in_range <= req_adr[31:2] < 30'(DEPTH);
                lat_we       <= grant_vid ? vid_we : cpu_we;
                lat_sel      <= cpu_sel;
                lat_dat      <= cpu_dat_m;
            end

            if (!cpu_cyc || grant_cpu)              starve_cnt <= '0;
            else if (grant_vid && cpu_req)          starve_cnt <= starve_cnt + SW'(1);

            if (!cpu_cyc || grant_cpu)              cpu_pend <= 1'b0;
            else if (state == S_IDLE && cpu_stb)    cpu_pend <= 1'b1;

            if (state == S_ACK && gnt_cyc) begin
                if (sel_vid) begin
                    vid_ack   <= 1'b1;
                    vid_dat_s <= rdata;
                end else begin
                    cpu_ack   <= 1'b1;
                    cpu_dat_s <= rdata;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (state == S_WR && lat_in_range) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (lat_sel[b]) mem[lat_idx][8*b +: 8] <= lat_dat[8*b +: 8];
            end
        end
        if (state == S_RD && lat_in_range) ram_q <= mem[lat_idx];
    end

endmodule
